// File: rtl/branch_flag_resolver.sv
// ============================================================================
// Module   : branch_flag_resolver
// Brief    : Latches compare-unit Z/S flags and resolves conditional branches
//            into taken/next-PC results over a valid/ready handshake.
//            Optional statistics counters are enabled by BRANCH_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_flag_resolver #(
    parameter int WIDTH      = 20,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flag_we,
    input  logic                  zero_in,
    input  logic                  sign_in,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [2:0]            br_cond,
    input  logic [WIDTH-1:0]      br_pc,
    input  logic [WIDTH-1:0]      br_target,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_taken,
    output logic [WIDTH-1:0]      res_next_pc,
    output logic                  res_err,
    output logic                  flags_valid,
    output logic [STAT_WIDTH-1:0] taken_count,
    output logic [STAT_WIDTH-1:0] resolved_count
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [2:0] C_COND_ALWAYS = 3'b000;
    localparam logic [2:0] C_COND_EQ     = 3'b001;
    localparam logic [2:0] C_COND_NE     = 3'b010;
    localparam logic [2:0] C_COND_S_SET  = 3'b011;
    localparam logic [2:0] C_COND_S_CLR  = 3'b100;
    localparam logic [2:0] C_COND_NEVER  = 3'b101;

    state_t             state_q, state_d;
    logic               z_q, z_d;
    logic               s_q, s_d;
    logic               fv_q, fv_d;
    logic               taken_q, taken_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   next_pc_q, next_pc_d;

    logic               accept;
    logic               eff_z;
    logic               eff_s;
    logic               eff_fv;
    logic               cond_taken;
    logic               cond_err;

    assign br_ready = (state_q == ST_EMPTY) | res_ready;
    assign accept   = br_valid & br_ready;

    // A flag write in the accept cycle is forwarded so the branch sees it.
    always_comb begin
        eff_z      = flag_we ? zero_in : z_q;
        eff_s      = flag_we ? sign_in : s_q;
        eff_fv     = flag_we | fv_q;
        cond_taken = 1'b0;
        cond_err   = 1'b0;
        case (br_cond)
            C_COND_ALWAYS: cond_taken = 1'b1;
            C_COND_EQ:     if (eff_fv) cond_taken = eff_z;  else cond_err = 1'b1;
            C_COND_NE:     if (eff_fv) cond_taken = !eff_z; else cond_err = 1'b1;
            C_COND_S_SET:  if (eff_fv) cond_taken = eff_s;  else cond_err = 1'b1;
            C_COND_S_CLR:  if (eff_fv) cond_taken = !eff_s; else cond_err = 1'b1;
            C_COND_NEVER:  cond_taken = 1'b0;
            default:       cond_err   = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        z_d       = z_q;
        s_d       = s_q;
        fv_d      = fv_q;
        taken_d   = taken_q;
        err_d     = err_q;
        next_pc_d = next_pc_q;

        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (accept)         state_d = ST_FULL;
                else if (res_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase

        if (accept) begin
            taken_d   = cond_taken;
            err_d     = cond_err;
            next_pc_d = cond_taken ? br_target : (br_pc + WIDTH'(1));
        end

        if (flag_we) begin
            z_d  = zero_in;
            s_d  = sign_in;
            fv_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            z_q       <= 1'b0;
            s_q       <= 1'b0;
            fv_q      <= 1'b0;
            taken_q   <= 1'b0;
            err_q     <= 1'b0;
            next_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            z_q       <= z_d;
            s_q       <= s_d;
            fv_q      <= fv_d;
            taken_q   <= taken_d;
            err_q     <= err_d;
            next_pc_q <= next_pc_d;
        end
    end

    assign res_valid   = (state_q == ST_FULL);
    assign res_taken   = taken_q;
    assign res_err     = err_q;
    assign res_next_pc = next_pc_q;
    assign flags_valid = fv_q;

`ifdef BRANCH_STATS_EN
    localparam logic [STAT_WIDTH-1:0] C_STAT_MAX = {STAT_WIDTH{1'b1}};

    logic [STAT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;
    logic [STAT_WIDTH-1:0] resolved_cnt_q, resolved_cnt_d;

    // Counters saturate rather than wrap.
    always_comb begin
        taken_cnt_d    = taken_cnt_q;
        resolved_cnt_d = resolved_cnt_q;
        if (accept && (resolved_cnt_q != C_STAT_MAX))
            resolved_cnt_d = resolved_cnt_q + STAT_WIDTH'(1);
        if (accept && cond_taken && (taken_cnt_q != C_STAT_MAX))
            taken_cnt_d = taken_cnt_q + STAT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt_q    <= '0;
            resolved_cnt_q <= '0;
        end else begin
            taken_cnt_q    <= taken_cnt_d;
            resolved_cnt_q <= resolved_cnt_d;
        end
    end

    assign taken_count    = taken_cnt_q;
    assign resolved_count = resolved_cnt_q;
`else
    assign taken_count    = '0;
    assign resolved_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_flag_resolver.sv
// ============================================================================
// Module   : tb_branch_flag_resolver
// Brief    : Directed bench for branch_flag_resolver with a transaction-level
//            reference model; honours BRANCH_STATS_EN for the counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_flag_resolver;

    localparam int WIDTH      = 20;
    localparam int STAT_WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flag_we = 1'b0;
    logic                  zero_in = 1'b0;
    logic                  sign_in = 1'b0;
    logic                  br_valid = 1'b0;
    logic                  br_ready;
    logic [2:0]            br_cond = 3'b000;
    logic [WIDTH-1:0]      br_pc = '0;
    logic [WIDTH-1:0]      br_target = '0;
    logic                  res_valid;
    logic                  res_ready = 1'b1;
    logic                  res_taken;
    logic [WIDTH-1:0]      res_next_pc;
    logic                  res_err;
    logic                  flags_valid;
    logic [STAT_WIDTH-1:0] taken_count;
    logic [STAT_WIDTH-1:0] resolved_count;

    int errors = 0;
    int checks = 0;

    branch_flag_resolver #(.WIDTH(WIDTH), .STAT_WIDTH(STAT_WIDTH)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we), .zero_in(zero_in),
        .sign_in(sign_in), .br_valid(br_valid), .br_ready(br_ready),
        .br_cond(br_cond), .br_pc(br_pc), .br_target(br_target),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
        .res_next_pc(res_next_pc), .res_err(res_err), .flags_valid(flags_valid),
        .taken_count(taken_count), .resolved_count(resolved_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending-result slot plus architectural flags.
    bit               m_z = 0, m_s = 0, m_fv = 0;
    bit               m_valid = 0, m_taken = 0, m_err = 0;
    logic [WIDTH-1:0] m_pc = '0;
    int               m_tc = 0, m_rc = 0;

    function automatic void resolve(input logic [2:0] c, input bit z, input bit s,
                                    input bit fv, output bit t, output bit e);
        t = 0; e = 0;
        if (c == 3'd0)      t = 1;
        else if (c == 3'd5) t = 0;
        else if (c > 3'd5)  e = 1;
        else if (!fv)       e = 1;
        else if (c == 3'd1) t = z;
        else if (c == 3'd2) t = !z;
        else if (c == 3'd3) t = s;
        else                t = !s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_z = 0; m_s = 0; m_fv = 0; m_valid = 0;
            m_taken = 0; m_err = 0; m_pc = '0; m_tc = 0; m_rc = 0;
        end else begin
            bit acc, t, e;
            acc = br_valid && (!m_valid || res_ready);
            if (acc) begin
                resolve(br_cond, flag_we ? zero_in : m_z, flag_we ? sign_in : m_s,
                        flag_we || m_fv, t, e);
                m_taken = t;
                m_err   = e;
                m_pc    = t ? br_target : WIDTH'(br_pc + 1);
                m_valid = 1;
`ifdef BRANCH_STATS_EN
                if (m_rc < (1 << STAT_WIDTH) - 1) m_rc++;
                if (t && m_tc < (1 << STAT_WIDTH) - 1) m_tc++;
`endif
            end else if (res_ready) begin
                m_valid = 0;
            end
            if (flag_we) begin
                m_z = zero_in; m_s = sign_in; m_fv = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("res_valid", 32'(res_valid), 32'(m_valid));
        chk("br_ready", 32'(br_ready), 32'(!m_valid || res_ready));
        chk("flags_valid", 32'(flags_valid), 32'(m_fv));
        chk("taken_count", 32'(taken_count), 32'(m_tc));
        chk("resolved_count", 32'(resolved_count), 32'(m_rc));
        if (m_valid) begin
            chk("res_taken", 32'(res_taken), 32'(m_taken));
            chk("res_err", 32'(res_err), 32'(m_err));
            chk("res_next_pc", 32'(res_next_pc), 32'(m_pc));
        end
    end

    task automatic drive(input bit fwe, input bit zi, input bit si, input bit bv,
                         input logic [2:0] c, input logic [WIDTH-1:0] pc,
                         input logic [WIDTH-1:0] tgt, input bit rr);
        flag_we = fwe; zero_in = zi; sign_in = si; br_valid = bv;
        br_cond = c; br_pc = pc; br_target = tgt; res_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string n, input bit v, input bit t, input bit e,
                       input logic [WIDTH-1:0] pc);
        chk({n, "_valid"}, 32'(res_valid), 32'(v));
        chk({n, "_taken"}, 32'(res_taken), 32'(t));
        chk({n, "_err"}, 32'(res_err), 32'(e));
        chk({n, "_pc"}, 32'(res_next_pc), 32'(pc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        lit("reset", 0, 0, 0, 20'h00000);
        chk("reset_fv", 32'(flags_valid), 32'd0);

        drive(0, 0, 0, 1, 3'b001, 20'h00010, 20'h00200, 1);
        lit("noflag_eq", 1, 0, 1, 20'h00011);
        chk("noflag_fv", 32'(flags_valid), 32'd0);

        drive(1, 1, 0, 0, 3'b000, 20'h0, 20'h0, 1);
        chk("fw_written", 32'(flags_valid), 32'd1);
        chk("drain_valid", 32'(res_valid), 32'd0);

        drive(0, 0, 0, 1, 3'b001, 20'h00010, 20'h00200, 1);
        lit("eq_taken", 1, 1, 0, 20'h00200);

        drive(1, 0, 0, 1, 3'b010, 20'h00020, 20'h00300, 1);
        lit("fwd_ne", 1, 1, 0, 20'h00300);

        drive(0, 0, 0, 1, 3'b111, 20'h00030, 20'h00400, 1);
        lit("illegal", 1, 0, 1, 20'h00031);

        drive(0, 0, 0, 1, 3'b101, 20'hFFFFF, 20'h00500, 1);
        lit("never_wrap", 1, 0, 0, 20'h00000);

        drive(1, 0, 1, 1, 3'b011, 20'h00070, 20'h01000, 1);
        lit("fwd_sset", 1, 1, 0, 20'h01000);
        drive(0, 0, 0, 1, 3'b100, 20'h00071, 20'h01100, 1);
        lit("sclr", 1, 0, 0, 20'h00072);
        drive(0, 0, 0, 1, 3'b000, 20'h00072, 20'h01200, 1);
        lit("always", 1, 1, 0, 20'h01200);

        drive(0, 0, 0, 1, 3'b000, 20'h00040, 20'h00600, 1);
        lit("pre_stall", 1, 1, 0, 20'h00600);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 3'b001, 20'h00050, 20'h00700, 0);
            chk("stall_ready", 32'(br_ready), 32'd0);
            lit("stall_hold", 1, 1, 0, 20'h00600);
        end
        drive(0, 0, 0, 1, 3'b001, 20'h00050, 20'h00700, 1);
        lit("b2b", 1, 0, 0, 20'h00051);

        drive(0, 0, 0, 1, 3'b000, 20'h00060, 20'h00800, 0);
        lit("ignored", 1, 0, 0, 20'h00051);
        #2 rst = 1'b1;
        #1;
        lit("midrst", 0, 0, 0, 20'h00000);
        chk("midrst_fv", 32'(flags_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, 1, 3'b001, 20'h00010, 20'h00200, 1);
        lit("postrst_eq", 1, 0, 1, 20'h00011);

        for (int i = 0; i < 20; i++)
            drive(0, 0, 0, 1, 3'b000, WIDTH'(i), 20'h00900, 1);
`ifdef BRANCH_STATS_EN
        chk("sat_taken", 32'(taken_count), 32'd15);
        chk("sat_resolved", 32'(resolved_count), 32'd15);
`else
        chk("nostat_taken", 32'(taken_count), 32'd0);
        chk("nostat_resolved", 32'(resolved_count), 32'd0);
`endif
        drive(0, 0, 0, 0, 3'b000, 20'h0, 20'h0, 1);
        chk("final_drain", 32'(res_valid), 32'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_flag_resolver.md
Name: branch_flag_resolver

Overview:
- Consumer side of the comparison flag path.
- Latches the zero/equals flag and the sign flag produced by the 20-bit compare units into an architectural flag register.
- Resolves conditional branch requests against those flags and returns taken/not-taken plus the next PC over a valid/ready handshake.
- Sits between the compare units and the fetch/PC-update logic.

Parameters:
- WIDTH, 20, PC/target width in bits.
- STAT_WIDTH, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flag_we  in  1  write the flag register this cycle.
- zero_in  in  1  equals flag from compare unit (1 = operands equal).
- sign_in  in  1  sign flag from compare unit.
- br_valid  in  1  branch request valid.
- br_ready  out  1  resolver can accept a request.
- br_cond  in  3  condition code.
- br_pc  in  WIDTH  PC of the branch instruction.
- br_target  in  WIDTH  branch target address.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_taken  out  1  branch taken.
- res_next_pc  out  WIDTH  resolved next PC.
- res_err  out  1  illegal condition, or conditional branch before any flag write.
- flags_valid  out  1  flag register has been written since reset.
- taken_count  out  STAT_WIDTH  taken branches (optional feature).
- resolved_count  out  STAT_WIDTH  resolved branches (optional feature).

Behaviour:
- Reset (async, immediate):
  - Z, S, flags_valid, res_valid, res_taken, res_err = 0.
  - res_next_pc = 0.
  - Counters = 0.
  - Any in-flight result is discarded; no partial handshake survives reset.
- Flag register: on a clk edge with flag_we=1, Z<=zero_in, S<=sign_in, flags_valid<=1. Flags hold otherwise.
- Condition codes:
  - 000 ALWAYS.
  - 001 EQ (Z=1).
  - 010 NE (Z=0).
  - 011 S_SET (S=1).
  - 100 S_CLR (S=0).
  - 101 NEVER.
  - 110/111 illegal: not taken, res_err=1.
- Forwarding: if flag_we=1 in the same cycle a request is accepted, evaluate using zero_in/sign_in, not the stale register, and treat flags as valid.
- Unwritten flags: a conditional code (001-100) with no valid flags (register and forwarding both absent) resolves as not taken with res_err=1. ALWAYS and NEVER never error.
- Next PC:
  - res_next_pc = taken ? br_target : br_pc+1, modulo 2^WIDTH.
  - br_pc = 0xFFFFF gives 0x00000.
- Handshake:
  - Accept when br_valid & br_ready.
  - br_ready = !res_valid | res_ready (combinational).
  - Latency 1: a request accepted at edge N gives res_valid=1 with results after edge N.
  - Result outputs hold stable while res_valid & !res_ready.
  - res_valid clears on the edge where res_ready=1 and no new request is accepted.
  - Back-to-back: accept + drain on the same edge loads the new result; res_valid stays 1.
- State machine, 2 states:
  - EMPTY (res_valid=0) -> FULL on accept.
  - FULL -> EMPTY on res_ready with no accept.
  - FULL -> FULL on stall, or on accept with drain.
- br_valid while !br_ready: request ignored; the requester must hold.
- Outputs are registered except br_ready.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - resolved_count increments on each accepted request.
  - taken_count increments on each accepted request that resolves taken.
  - Both saturate at 2^STAT_WIDTH-1 (no wrap) and clear on rst.
- Undefined: both counter ports are driven constant 0 and no counter flops are built; all other behaviour is identical.

Test Plan:
- Reset then cond=001, pc=0x00010, target=0x00200, no flag write -> res_taken=0, res_err=1, res_next_pc=0x00011, flags_valid=0.
- flag_we with zero_in=1, sign_in=0; next cycle cond=001, pc=0x00010, target=0x00200 -> res_valid one cycle after accept, res_taken=1, res_next_pc=0x00200, res_err=0.
- Same-cycle flag_we (zero_in=0) with cond=010 request, register Z=1 -> forwarded value used: res_taken=1; cond=111 -> res_taken=0, res_err=1.
- cond=101, pc=0xFFFFF -> res_next_pc=0x00000, res_taken=0.
- Hold res_ready=0 for 3 cycles with br_valid=1 -> br_ready=0, outputs stable. Then res_ready=1 with a new request -> back-to-back result, res_valid stays 1. Assert rst mid-stall -> res_valid=0 immediately, Z=S=0.
- With BRANCH_STATS_EN and STAT_WIDTH=4: 20 ALWAYS branches -> taken_count=resolved_count=15 (saturated). Without the macro -> both read 0.
